// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word at a time and sends it as a UART frame (start, LSB-first data, stop).
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  output logic             fifo_rd_en_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [2:0]       dbg_state_o
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [WIDTH-1:0]     shift;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                 parity;
`endif

  logic bit_end;
  assign bit_end = (cnt == LAST_CNT);

  // Pop handshake: rd_en is a single-cycle request issued only after empty was seen low in IDLE;
  // the popped word is valid on fifo_rdata_i in the following (LOAD) cycle. No back-pressure.
  assign fifo_rd_en_o = (state == REQ);
  assign busy_o       = (state != IDLE);
  assign dbg_state_o  = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      tx_o    <= 1'b1;
      done_o  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (!fifo_empty_i) state <= REQ;
        end
        REQ: begin
          tx_o  <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          tx_o    <= 1'b1;
          shift   <= fifo_rdata_i;
`ifdef FIFO_UART_TX_PARITY_EN
          parity  <= ^fifo_rdata_i;
`endif
          cnt     <= '0;
          bit_idx <= '0;
          state   <= START;
        end
        START: begin
          tx_o <= 1'b0;
          if (bit_end) begin
            cnt   <= '0;
            state <= DATA;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        DATA: begin
          // tx_o follows the state by one cycle, so the line lags the shift register.
          tx_o <= shift[0];
          if (bit_end) begin
            cnt   <= '0;
            shift <= shift >> 1;
            if (bit_idx == LAST_IDX) begin
              bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          tx_o <= parity;
          if (bit_end) begin
            cnt   <= '0;
            state <= STOP;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
`endif
        STOP: begin
          tx_o <= 1'b1;
          if (bit_end) begin
            cnt    <= '0;
            done_o <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          tx_o  <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO, line decoder checking every cycle of every frame against
// the words written, and directed plus random scenarios.
module tb_fifo_uart_tx;

  localparam int W   = 8;
  localparam int CPB = 4;
  localparam int DEPTH = 16;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FB = W + 2 + PB;
  localparam int FL = FB * CPB;

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_empty;
  logic [W-1:0] fifo_rdata;
  logic         fifo_rd_en;
  logic         tx;
  logic         busy;
  logic         done;
  logic [2:0]   dbg_state;

  logic         wr_en;
  logic [W-1:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;
  int pops = 0, fifo_err = 0, fifo_ovf = 0, n_written = 0;
  int done_cnt = 0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];

  // monitor state
  bit            in_frame = 1'b0;
  int            cyc = 0;
  int            idle_run = 0;
  int            last_gap = -1;
  logic [FB-1:0] frame_bits = '0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .CNT_WIDTH(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .fifo_empty_i(fifo_empty),
    .fifo_rdata_i(fifo_rdata),
    .fifo_rd_en_o(fifo_rd_en),
    .tx_o        (tx),
    .busy_o      (busy),
    .done_o      (done),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FB-1:0] build_frame(input logic [W-1:0] w);
    logic [FB-1:0] b;
    b = '0;
    for (int i = 0; i < W; i++) b[i+1] = w[i];
    if (PB == 1) b[W+1] = ^w;
    b[FB-1] = 1'b1;
    return b;
  endfunction

  // Behavioural FIFO: rdata registered on the edge that samples rd_en, empty registered.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      pops++;
      if (fifo_q.size() == 0) fifo_err++;
      else fifo_rdata <= fifo_q.pop_front();
    end
    if (wr_en) begin
      if (fifo_q.size() == DEPTH) fifo_ovf++;
      else fifo_q.push_back(wr_data);
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Line decoder: a falling line starts a frame; every cycle is compared with the expected bit.
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      idle_run = 0;
    end else begin
      if (!in_frame) begin
        if (tx === 1'b0) begin
          check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) frame_bits = build_frame(exp_q.pop_front());
          in_frame = 1'b1;
          cyc = 0;
          last_gap = idle_run;
        end else begin
          idle_run++;
        end
      end
      if (in_frame) begin
        check("tx_bit", 32'(tx), 32'(frame_bits[cyc / CPB]));
        check("done_timing", 32'(done), 32'(cyc == FL - 1));
        if (cyc == FL - 1) begin
          in_frame = 1'b0;
          idle_run = 0;
        end else begin
          cyc++;
        end
      end else begin
        check("done_idle", 32'(done), 32'd0);
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [W-1:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    exp_q.push_back(w);
    n_written++;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    tick(2);
    while (k < 3000 && (exp_q.size() != 0 || in_frame || busy || fifo_q.size() != 0)) begin
      tick(1);
      k++;
    end
    check(tag, 32'(k < 3000), 32'd1);
  endtask

  initial begin
    int d0, k;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    tick(2);
    rst = 1'b0;

    // 1: idle after reset, empty FIFO
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      @(posedge clk);
      #1;
    end
    check("rst_pops", pops, 0);

    // 2: single word
    d0 = done_cnt;
    wr(8'hA5);
    drain("drain_a5");
    check("a5_pops", pops, 1);
    check("a5_done", done_cnt - d0, 1);
    check("a5_fifo_err", fifo_err, 0);

    // 3: back-to-back
    wr(8'h00);
    wr(8'hFF);
    drain("drain_b2b");
    check("b2b_pops", pops, 3);
    check("b2b_gap", last_gap, 3);
    check("b2b_empty", 32'(fifo_empty), 32'd1);

    // 4: reset in the middle of the data bits
    wr(8'h3C);
    k = 0;
    while (k < 400 && !(in_frame && cyc >= 4 * CPB)) begin
      tick(1);
      k++;
    end
    check("reach_data", 32'(k < 400), 32'd1);
    d0 = done_cnt;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    tick(3 * FL);
    check("abort_no_done", done_cnt - d0, 0);
    wr(8'h11);
    drain("drain_11");

`ifdef FIFO_UART_TX_PARITY_EN
    // 5: parity frames
    wr(8'h07);
    drain("drain_07");
    wr(8'h03);
    drain("drain_03");
`endif

    // 6: fill the FIFO with a random burst
    d0 = done_cnt;
    for (int i = 0; i < DEPTH; i++) wr(W'($urandom_range(0, 255)));
    drain("drain_burst");
    check("burst_done", done_cnt - d0, DEPTH);
    check("burst_gap", last_gap, 3);
    tick(2);
    check("burst_busy", 32'(busy), 32'd0);

    // random spacing
    for (int i = 0; i < 10; i++) begin
      tick($urandom_range(0, 60));
      wr(W'($urandom));
    end
    drain("drain_rand");

    check("pop_count", pops, n_written);
    check("fifo_err", fifo_err, 0);
    check("fifo_ovf", fifo_ovf, 0);
    check("exp_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
